zba_pipe: RTL and testbench
===========================

ZBA_PIPE -- requirements
Module: zba_pipe

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 The block SHALL have parameter STAGES, default 1, number of result register stages; legal values 1 to 4.
REQ-003 The block SHALL have parameter TAG_W, default 5, width of the passthrough tag (destination register index).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 flush  input  1  synchronous discard of all in-flight operations.
REQ-007 in_valid  input  1  request present.
REQ-008 in_ready  output  1  block accepts request this cycle.
REQ-009 in_op  input  3  operation, zba_op_t.
REQ-010 in_rs1  input  XLEN  shifted operand.
REQ-011 in_rs2  input  XLEN  addend.
REQ-012 in_tag  input  TAG_W  opaque tag, returned with result.
REQ-013 out_valid  output  1  result present.
REQ-014 out_ready  input  1  consumer accepts result.
REQ-015 out_result  output  XLEN  computed result.
REQ-016 out_tag  output  TAG_W  tag of the result.
REQ-017 out_illegal  output  1  op was illegal for this XLEN; out_result is 0.

Function
REQ-018 Ops: SH1ADD=000, SH2ADD=001, SH3ADD=010: result = (rs1 << n) + rs2, n = 1, 2, 3.
REQ-019 ADD_UW=011, SH1ADD_UW=100, SH2ADD_UW=101, SH3ADD_UW=110: result = (zext32(rs1[31:0]) << n) + rs2, n = 0, 1, 2, 3.
REQ-020 All arithmetic SHALL be modulo 2^XLEN; shifted-out bits and carry-out are discarded.
REQ-021 Op 111, and every *_UW op when XLEN=32, SHALL produce out_result=0 and out_illegal=1; otherwise out_illegal=0.
REQ-022 Computation SHALL be combinational on the inputs; the result is captured into stage 1 on handshake (in_valid & in_ready).
REQ-023 Latency SHALL be exactly STAGES cycles from the accept edge to out_valid with no backpressure; throughput 1 op per cycle.
REQ-024 Each stage k SHALL hold valid, result, tag, illegal; stage k loads from stage k-1 when stage k is empty or advancing.
REQ-025 A stage SHALL advance when it is the last stage and out_ready=1, or when the next stage loads it.
REQ-026 in_ready SHALL equal (stage-1 empty) or (stage 1 advancing), combinationally; no bubbles under continuous flow.
REQ-027 With out_ready=0 the block SHALL hold exactly STAGES results, then deassert in_ready; no result is dropped or duplicated.
REQ-028 out_result, out_tag and out_illegal SHALL remain stable while out_valid=1 and out_ready=0.
REQ-029 flush=1 SHALL clear every valid bit at the next edge and block acceptance that cycle (in_ready=0); data registers may keep stale values.
REQ-030 flush SHALL take priority over a simultaneous input handshake and a simultaneous output handshake; the output handshake in that cycle still counts as consumed.
REQ-031 Results SHALL emerge in acceptance order.

Reset
REQ-032 reset_n=0 SHALL immediately clear all stage valid bits, out_valid=0, out_result=0, out_tag=0, out_illegal=0.
REQ-033 in_ready SHALL be 1 in the first cycle after reset_n deasserts; in-flight operations at reset are discarded.

Structure
REQ-034 zba_op_t (3-bit enum) and the op encodings SHALL live in the shared package zba_pkg.
REQ-035 One pipeline slice SHALL be a sub-module zba_stage (valid/data register with ready/valid), instantiated STAGES times via generate.
REQ-036 Illegal parameter values SHALL fail elaboration.

Verification
REQ-037 XLEN=32, STAGES=1: SH2ADD rs1=0x00000003, rs2=0x00000010 -> out_result=0x0000001C one cycle later, out_illegal=0.
REQ-038 XLEN=32: SH3ADD rs1=0x20000000, rs2=0x00000001 -> 0x00000001 (wrap); SH1ADD_UW -> 0, out_illegal=1.
REQ-039 XLEN=64: SH1ADD_UW rs1=0xFFFFFFFF80000001, rs2=0 -> 0x0000000100000002; ADD_UW same rs1, rs2=1 -> 0x0000000080000002.
REQ-040 STAGES=2, out_ready=0, 3 back-to-back requests tags 1,2,3 -> in_ready=0 after tags 1,2 accepted; release out_ready -> tags 1,2,3 in order, no loss.
REQ-041 STAGES=3, 3 ops in flight, flush=1 for one cycle with in_valid=1 -> no out_valid afterwards, the flushed-cycle request not accepted.
REQ-042 reset_n pulsed low mid-stream -> out_valid=0 immediately, in_ready=1 next cycle, next op returns correct result after STAGES cycles.

Source files
------------

// File: rtl/zba_pkg.sv
// Shared definitions for the Zba shift-and-add pipeline: op encodings and decode helpers.
package zba_pkg;

    typedef enum logic [2:0] {
        OP_SH1ADD    = 3'b000,
        OP_SH2ADD    = 3'b001,
        OP_SH3ADD    = 3'b010,
        OP_ADD_UW    = 3'b011,
        OP_SH1ADD_UW = 3'b100,
        OP_SH2ADD_UW = 3'b101,
        OP_SH3ADD_UW = 3'b110,
        OP_RSVD      = 3'b111
    } zba_op_t;

    // Left-shift amount applied to rs1 for each op.
    function automatic logic [1:0] zba_shamt(input zba_op_t op);
        logic [1:0] n;
        case (op)
            OP_SH1ADD, OP_SH1ADD_UW: n = 2'd1;
            OP_SH2ADD, OP_SH2ADD_UW: n = 2'd2;
            OP_SH3ADD, OP_SH3ADD_UW: n = 2'd3;
            default:                 n = 2'd0;
        endcase
        return n;
    endfunction

    // Ops that zero-extend the low word of rs1 before shifting (RV64-only).
    function automatic logic zba_is_uw(input zba_op_t op);
        logic uw;
        case (op)
            OP_ADD_UW, OP_SH1ADD_UW, OP_SH2ADD_UW, OP_SH3ADD_UW: uw = 1'b1;
            default:                                             uw = 1'b0;
        endcase
        return uw;
    endfunction

endpackage

// File: rtl/zba_stage.sv
// One elastic pipeline slice: a valid bit plus payload register with ready/valid on both sides.
module zba_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         flush,
    input  logic         up_valid,
    output logic         up_ready,
    input  logic [W-1:0] up_data,
    output logic         dn_valid,
    input  logic         dn_ready,
    output logic [W-1:0] dn_data
);

    logic         valid_r;
    logic [W-1:0] data_r;
    logic         load_s;

    // Empty or draining this cycle means a new entry can be taken.
    assign up_ready = ~valid_r | dn_ready;
    assign load_s   = up_valid & up_ready & ~flush;
    assign dn_valid = valid_r;
    assign dn_data  = data_r;

    // Valid/payload register; flush drops the entry but leaves payload stale.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_r <= 1'b0;
            data_r  <= '0;
        end else if (flush) begin
            valid_r <= 1'b0;
        end else begin
            if (up_ready) begin
                valid_r <= up_valid;
            end
            if (load_s) begin
                data_r <= up_data;
            end
        end
    end

endmodule

// File: rtl/zba_pipe.sv
// Zba address-generation unit (shNadd / shNadd.uw / add.uw) with a STAGES-deep
// elastic result pipeline carrying a passthrough tag.
module zba_pipe
    import zba_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STAGES = 1,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  zba_op_t          in_op,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    localparam int          PW        = XLEN + TAG_W + 1;
    localparam logic [63:0] UW_MASK64 = 64'h0000_0000_FFFF_FFFF;

    if (!(XLEN == 32'sd32 || XLEN == 32'sd64)) begin : g_bad_xlen
        $error("zba_pipe: XLEN must be 32 or 64");
    end
    if (STAGES < 32'sd1 || STAGES > 32'sd4) begin : g_bad_stages
        $error("zba_pipe: STAGES must be 1..4");
    end
    if (TAG_W < 32'sd1) begin : g_bad_tag
        $error("zba_pipe: TAG_W must be at least 1");
    end

    logic [XLEN-1:0] uw_mask_s;
    logic [XLEN-1:0] operand_s;
    logic [XLEN-1:0] result_s;
    logic            illegal_s;

    assign uw_mask_s = UW_MASK64[XLEN-1:0];

    // Shift-and-add datapath; illegal ops (reserved, or .uw on RV32) yield zero.
    always_comb begin
        operand_s = in_rs1;
        result_s  = '0;
        illegal_s = 1'b0;
        if (in_op == OP_RSVD || (zba_is_uw(in_op) && XLEN == 32'sd32)) begin
            illegal_s = 1'b1;
        end else begin
            if (zba_is_uw(in_op)) begin
                operand_s = in_rs1 & uw_mask_s;
            end else begin
                operand_s = in_rs1;
            end
            result_s = (operand_s << zba_shamt(in_op)) + in_rs2;
        end
    end

    // Index 0 is the request side, index STAGES the result side.
    logic          v_s [0:STAGES];
    logic          r_s [0:STAGES];
    logic [PW-1:0] d_s [0:STAGES];

    assign v_s[0]      = in_valid;
    assign d_s[0]      = {illegal_s, in_tag, result_s};
    assign r_s[STAGES] = out_ready;
    assign in_ready    = r_s[0] & ~flush;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        zba_stage #(.W(PW)) u_stage (
            .clk      (clk),
            .reset_n  (reset_n),
            .flush    (flush),
            .up_valid (v_s[k]),
            .up_ready (r_s[k]),
            .up_data  (d_s[k]),
            .dn_valid (v_s[k+1]),
            .dn_ready (r_s[k+1]),
            .dn_data  (d_s[k+1])
        );
    end

    assign out_valid                            = v_s[STAGES];
    assign {out_illegal, out_tag, out_result}   = d_s[STAGES];

endmodule

// File: tb/tb_zba_pipe.sv
// Directed bench for zba_pipe: three instances (RV32/1 stage, RV64/2 stages, RV32/3 stages).
module tb_zba_pipe;
    import zba_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Instance A: XLEN=32, STAGES=1
    logic a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_illegal;
    zba_op_t a_in_op;
    logic [31:0] a_in_rs1, a_in_rs2, a_out_result;
    logic [4:0]  a_in_tag, a_out_tag;

    // Instance B: XLEN=64, STAGES=2
    logic b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_illegal;
    zba_op_t b_in_op;
    logic [63:0] b_in_rs1, b_in_rs2, b_out_result;
    logic [4:0]  b_in_tag, b_out_tag;

    // Instance C: XLEN=32, STAGES=3
    logic c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_illegal;
    zba_op_t c_in_op;
    logic [31:0] c_in_rs1, c_in_rs2, c_out_result;
    logic [4:0]  c_in_tag, c_out_tag;

    zba_pipe #(.XLEN(32), .STAGES(1), .TAG_W(5)) u_a (
        .clk(clk), .reset_n(reset_n), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_op(a_in_op),
        .in_rs1(a_in_rs1), .in_rs2(a_in_rs2), .in_tag(a_in_tag),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_result(a_out_result),
        .out_tag(a_out_tag), .out_illegal(a_out_illegal)
    );

    zba_pipe #(.XLEN(64), .STAGES(2), .TAG_W(5)) u_b (
        .clk(clk), .reset_n(reset_n), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_op(b_in_op),
        .in_rs1(b_in_rs1), .in_rs2(b_in_rs2), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_result(b_out_result),
        .out_tag(b_out_tag), .out_illegal(b_out_illegal)
    );

    zba_pipe #(.XLEN(32), .STAGES(3), .TAG_W(5)) u_c (
        .clk(clk), .reset_n(reset_n), .flush(c_flush),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_op(c_in_op),
        .in_rs1(c_in_rs1), .in_rs2(c_in_rs2), .in_tag(c_in_tag),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_result(c_out_result),
        .out_tag(c_out_tag), .out_illegal(c_out_illegal)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive_a(input zba_op_t op, input logic [31:0] rs1, input logic [31:0] rs2, input logic [4:0] tag);
        a_in_valid = 1'b1; a_in_op = op; a_in_rs1 = rs1; a_in_rs2 = rs2; a_in_tag = tag;
    endtask

    task automatic drive_b(input zba_op_t op, input logic [63:0] rs1, input logic [63:0] rs2, input logic [4:0] tag);
        b_in_valid = 1'b1; b_in_op = op; b_in_rs1 = rs1; b_in_rs2 = rs2; b_in_tag = tag;
    endtask

    task automatic drive_c(input zba_op_t op, input logic [31:0] rs1, input logic [31:0] rs2, input logic [4:0] tag);
        c_in_valid = 1'b1; c_in_op = op; c_in_rs1 = rs1; c_in_rs2 = rs2; c_in_tag = tag;
    endtask

    initial begin
        reset_n = 1'b1;
        a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1; a_in_op = OP_SH1ADD;
        a_in_rs1 = 32'd0; a_in_rs2 = 32'd0; a_in_tag = 5'd0;
        b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1; b_in_op = OP_SH1ADD;
        b_in_rs1 = 64'd0; b_in_rs2 = 64'd0; b_in_tag = 5'd0;
        c_flush = 1'b0; c_in_valid = 1'b0; c_out_ready = 1'b1; c_in_op = OP_SH1ADD;
        c_in_rs1 = 32'd0; c_in_rs2 = 32'd0; c_in_tag = 5'd0;
        #1 reset_n = 1'b0;
        #1;
        chk("rst_a_valid",   {63'd0, a_out_valid}, 64'd0);
        chk("rst_a_result",  {32'd0, a_out_result}, 64'd0);
        chk("rst_a_tag",     {59'd0, a_out_tag}, 64'd0);
        chk("rst_a_illegal", {63'd0, a_out_illegal}, 64'd0);
        chk("rst_b_valid",   {63'd0, b_out_valid}, 64'd0);
        chk("rst_b_result",  b_out_result, 64'd0);
        chk("rst_c_valid",   {63'd0, c_out_valid}, 64'd0);
        step(); step();
        reset_n = 1'b1;
        #1;
        chk("rst_a_in_ready", {63'd0, a_in_ready}, 64'd1);
        chk("rst_b_in_ready", {63'd0, b_in_ready}, 64'd1);
        chk("rst_c_in_ready", {63'd0, c_in_ready}, 64'd1);

        // ---- A: RV32, one stage ----
        drive_a(OP_SH2ADD, 32'h0000_0003, 32'h0000_0010, 5'd7);
        step();
        chk("a_sh2add_valid",  {63'd0, a_out_valid}, 64'd1);
        chk("a_sh2add_result", {32'd0, a_out_result}, 64'h1C);
        chk("a_sh2add_tag",    {59'd0, a_out_tag}, 64'd7);
        chk("a_sh2add_ill",    {63'd0, a_out_illegal}, 64'd0);
        drive_a(OP_SH3ADD, 32'h2000_0000, 32'h0000_0001, 5'd3);
        step();
        chk("a_sh3add_wrap",   {32'd0, a_out_result}, 64'h1);
        chk("a_sh3add_tag",    {59'd0, a_out_tag}, 64'd3);
        drive_a(OP_SH1ADD_UW, 32'h0000_0001, 32'h0000_0002, 5'd4);
        step();
        chk("a_uw_result",     {32'd0, a_out_result}, 64'd0);
        chk("a_uw_ill",        {63'd0, a_out_illegal}, 64'd1);
        drive_a(OP_RSVD, 32'h0000_0005, 32'h0000_0005, 5'd5);
        step();
        chk("a_rsvd_result",   {32'd0, a_out_result}, 64'd0);
        chk("a_rsvd_ill",      {63'd0, a_out_illegal}, 64'd1);
        drive_a(OP_SH1ADD, 32'h8000_0001, 32'h0000_0005, 5'd6);
        step();
        chk("a_sh1add_result", {32'd0, a_out_result}, 64'h7);
        chk("a_sh1add_ill",    {63'd0, a_out_illegal}, 64'd0);
        a_in_valid = 1'b0;
        step();
        chk("a_idle_valid",    {63'd0, a_out_valid}, 64'd0);

        // ---- B: RV64, two stages, streaming ----
        drive_b(OP_SH1ADD_UW, 64'hFFFF_FFFF_8000_0001, 64'd0, 5'd4);
        step();
        chk("b_lat_not_yet",   {63'd0, b_out_valid}, 64'd0);
        drive_b(OP_ADD_UW, 64'hFFFF_FFFF_8000_0001, 64'd1, 5'd5);
        step();
        chk("b_sh1uw_result",  b_out_result, 64'h0000_0001_0000_0002);
        chk("b_sh1uw_tag",     {59'd0, b_out_tag}, 64'd4);
        chk("b_sh1uw_ill",     {63'd0, b_out_illegal}, 64'd0);
        drive_b(OP_SH3ADD, 64'h2000_0000_0000_0001, 64'd0, 5'd6);
        step();
        chk("b_adduw_result",  b_out_result, 64'h0000_0000_8000_0002);
        chk("b_adduw_tag",     {59'd0, b_out_tag}, 64'd5);
        drive_b(OP_RSVD, 64'h1234, 64'h5678, 5'd7);
        step();
        chk("b_sh3_wrap",      b_out_result, 64'h8);
        b_in_valid = 1'b0;
        step();
        chk("b_rsvd_result",   b_out_result, 64'd0);
        chk("b_rsvd_ill",      {63'd0, b_out_illegal}, 64'd1);
        chk("b_rsvd_tag",      {59'd0, b_out_tag}, 64'd7);
        step();
        chk("b_drain_valid",   {63'd0, b_out_valid}, 64'd0);

        // ---- B: backpressure, tags 1,2,3 ----
        b_out_ready = 1'b0;
        drive_b(OP_SH1ADD, 64'd1, 64'd0, 5'd1);
        #1 chk("bp_ready_t1",  {63'd0, b_in_ready}, 64'd1);
        step();
        drive_b(OP_SH1ADD, 64'd2, 64'd0, 5'd2);
        #1 chk("bp_ready_t2",  {63'd0, b_in_ready}, 64'd1);
        step();
        drive_b(OP_SH1ADD, 64'd3, 64'd0, 5'd3);
        #1 chk("bp_full_t3",   {63'd0, b_in_ready}, 64'd0);
        chk("bp_out_t1",       {59'd0, b_out_tag}, 64'd1);
        chk("bp_out_valid",    {63'd0, b_out_valid}, 64'd1);
        step();
        chk("bp_hold_ready",   {63'd0, b_in_ready}, 64'd0);
        chk("bp_hold_tag",     {59'd0, b_out_tag}, 64'd1);
        chk("bp_hold_result",  b_out_result, 64'd2);
        b_out_ready = 1'b1;
        #1 chk("bp_release_rdy", {63'd0, b_in_ready}, 64'd1);
        step();
        b_in_valid = 1'b0;
        chk("bp_out_t2",       {59'd0, b_out_tag}, 64'd2);
        chk("bp_out_r2",       b_out_result, 64'd4);
        step();
        chk("bp_out_t3",       {59'd0, b_out_tag}, 64'd3);
        chk("bp_out_r3",       b_out_result, 64'd6);
        step();
        chk("bp_empty",        {63'd0, b_out_valid}, 64'd0);

        // ---- C: RV32, three stages, flush ----
        drive_c(OP_SH1ADD, 32'd1, 32'd0, 5'd1);
        step();
        drive_c(OP_SH1ADD, 32'd2, 32'd0, 5'd2);
        step();
        drive_c(OP_SH1ADD, 32'd3, 32'd0, 5'd3);
        step();
        drive_c(OP_SH1ADD, 32'd4, 32'd0, 5'd9);
        c_flush = 1'b1;
        #1 chk("fl_in_ready",  {63'd0, c_in_ready}, 64'd0);
        chk("fl_out_t1",       {59'd0, c_out_tag}, 64'd1);
        step();
        c_flush = 1'b0;
        c_in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("fl_no_valid", {63'd0, c_out_valid}, 64'd0);
            step();
        end
        drive_c(OP_SH2ADD, 32'd2, 32'd1, 5'd11);
        step();
        c_in_valid = 1'b0;
        chk("fl_new_lat1",     {63'd0, c_out_valid}, 64'd0);
        step();
        chk("fl_new_lat2",     {63'd0, c_out_valid}, 64'd0);
        step();
        chk("fl_new_result",   {32'd0, c_out_result}, 64'd9);
        chk("fl_new_tag",      {59'd0, c_out_tag}, 64'd11);
        step();
        chk("fl_new_drain",    {63'd0, c_out_valid}, 64'd0);

        // ---- C: asynchronous reset mid-stream ----
        drive_c(OP_SH1ADD, 32'd3, 32'd0, 5'd12);
        step();
        drive_c(OP_SH1ADD, 32'd4, 32'd0, 5'd13);
        step();
        drive_c(OP_SH1ADD, 32'd5, 32'd0, 5'd14);
        step();
        c_in_valid = 1'b0;
        chk("mr_pre_tag",      {59'd0, c_out_tag}, 64'd12);
        chk("mr_pre_result",   {32'd0, c_out_result}, 64'd6);
        #2 reset_n = 1'b0;
        #1;
        chk("mr_valid_low",    {63'd0, c_out_valid}, 64'd0);
        chk("mr_result_zero",  {32'd0, c_out_result}, 64'd0);
        chk("mr_tag_zero",     {59'd0, c_out_tag}, 64'd0);
        step();
        reset_n = 1'b1;
        #1 chk("mr_in_ready",  {63'd0, c_in_ready}, 64'd1);
        drive_c(OP_SH3ADD, 32'd1, 32'd1, 5'd16);
        step();
        c_in_valid = 1'b0;
        chk("mr_lat1",         {63'd0, c_out_valid}, 64'd0);
        step();
        chk("mr_lat2",         {63'd0, c_out_valid}, 64'd0);
        step();
        chk("mr_result",       {32'd0, c_out_result}, 64'd9);
        chk("mr_tag",          {59'd0, c_out_tag}, 64'd16);
        step();
        chk("mr_drain",        {63'd0, c_out_valid}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
